// File: rtl/cpu_csr_unit.sv
// cpu_csr_unit: initiator side of the CSR access interface.
// Runs Zicsr instructions, trap entry and mret as a read-modify-write
// sequence (IDLE -> READ -> WRITE -> RESP) against a CSR file that returns
// read data combinationally and captures writes on the clk edge.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_*_i / req_ready_o    request handshake and latched request fields
//   resp_*_o / resp_ready_i  registered response (old value, redirect, illegal)
//   csr_*                    CSR file read/write port
module cpu_csr_unit #(
   parameter logic [11:0] CSR_MTVEC = 12'h305,
   parameter logic [11:0] CSR_MEPC  = 12'h341
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_kind_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [11:0] req_csr_i,
   input  logic [31:0] req_src_i,
   input  logic [4:0]  req_rs1_i,
   input  logic [31:0] req_pc_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_redirect_o,
   output logic [31:0] resp_target_o,
   output logic        resp_illegal_o,
   output logic [11:0] csr_raddr_o,
   input  logic [31:0] csr_rdata_i,
   output logic [11:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o,
   output logic        csr_wenable_o
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   state_t      state_q;
   logic [1:0]  kind_q;
   logic [2:0]  funct3_q;
   logic [11:0] csr_q;
   logic [31:0] src_q, pc_q, old_q;
   logic [4:0]  rs1_q;
   logic        resp_valid_q, resp_redirect_q, resp_illegal_q;
   logic [31:0] resp_rdata_q, resp_target_q;
   logic        illegal, we, in_write;
   logic [31:0] operand, wdata;
   assign illegal  = kind_q == 2'b11 || (kind_q == 2'b00 && funct3_q[1:0] == 2'b00);
   assign operand  = funct3_q[2] ? {27'b0, rs1_q} : src_q;
   // set/clear forms with rs1/zimm == 0 read only; write forms always write
   assign we       = kind_q == 2'b01 ||
                     (!illegal && kind_q == 2'b00 && (funct3_q[1:0] == 2'b01 || rs1_q != '0));
   assign wdata    = kind_q == 2'b01            ? {pc_q[31:2], 2'b00} :
                     funct3_q[1:0] == 2'b01     ? operand :
                     funct3_q[1:0] == 2'b10     ? (old_q | operand) :
                                                  (old_q & ~operand);
   assign in_write = state_q == WRITE;
   // rst_ni gating drops the strobe in the same cycle reset asserts
   assign csr_wenable_o   = rst_ni && in_write && we;
   assign csr_waddr_o     = in_write ? (kind_q == 2'b01 ? CSR_MEPC : csr_q) : '0;
   assign csr_wdata_o     = in_write ? wdata : '0;
   assign csr_raddr_o     = state_q != READ   ? '0 :
                            kind_q == 2'b01   ? CSR_MTVEC :
                            kind_q == 2'b10   ? CSR_MEPC : csr_q;
   assign req_ready_o     = rst_ni && state_q == IDLE;
   assign resp_valid_o    = resp_valid_q;
   assign resp_rdata_o    = resp_rdata_q;
   assign resp_redirect_o = resp_redirect_q;
   assign resp_target_o   = resp_target_q;
   assign resp_illegal_o  = resp_illegal_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         kind_q          <= '0;
         funct3_q        <= '0;
         csr_q           <= '0;
         src_q           <= '0;
         rs1_q           <= '0;
         pc_q            <= '0;
         old_q           <= '0;
         resp_valid_q    <= 1'b0;
         resp_rdata_q    <= '0;
         resp_redirect_q <= 1'b0;
         resp_target_q   <= '0;
         resp_illegal_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid_i) begin
               kind_q   <= req_kind_i;
               funct3_q <= req_funct3_i;
               csr_q    <= req_csr_i;
               src_q    <= req_src_i;
               rs1_q    <= req_rs1_i;
               pc_q     <= req_pc_i;
               state_q  <= READ;
            end
            READ: begin
               old_q   <= csr_rdata_i;
               state_q <= WRITE;
            end
            WRITE: begin
               resp_valid_q    <= 1'b1;
               resp_illegal_q  <= illegal;
               resp_redirect_q <= !illegal && kind_q != 2'b00;
               resp_rdata_q    <= (!illegal && kind_q == 2'b00) ? old_q : '0;
               resp_target_q   <= illegal          ? '0 :
                                  kind_q == 2'b01  ? {old_q[31:2], 2'b00} :
                                  kind_q == 2'b10  ? old_q : '0;
               state_q         <= RESP;
            end
            RESP: if (resp_ready_i) begin
               resp_valid_q    <= 1'b0;
               resp_rdata_q    <= '0;
               resp_redirect_q <= 1'b0;
               resp_target_q   <= '0;
               resp_illegal_q  <= 1'b0;
               state_q         <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
